// File: rtl/riscv_boot_pkg.sv
// riscv_boot_pkg: shared types and constants for the boot controller.
// Boot FSM states, default halt encoding (jal x0,0), program word-count helper.
package riscv_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    DONE
  } boot_state_t;

  localparam logic [31:0] HALT_DEFAULT = 32'h0000_006F;

  // Number of 32-bit words that fit below last byte address prog_size.
  function automatic int word_count(input int prog_size);
    return (prog_size + 1) / 4;
  endfunction

endpackage

// File: rtl/boot_run_counter.sv
// boot_run_counter: saturating core-run cycle counter with timeout compare.
// Ports: clk, rst (async high), i_clr, i_en, o_cnt (count), o_expire (next edge hits TIMEOUT).
module boot_run_counter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_en,
  output logic [XLEN-1:0] o_cnt,
  output logic            o_expire
);

  logic [XLEN-1:0] r_cnt;
  logic            w_sat;

  assign w_sat = &r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // High during the cycle whose closing edge brings the count to TIMEOUT.
  assign o_expire = i_en && (r_cnt >= XLEN'(TIMEOUT - 1));
  assign o_cnt    = r_cnt;

endmodule

// File: rtl/riscv_boot_ctrl.sv
// riscv_boot_ctrl: program loader and run supervisor for the riscv core.
// Ports: start/ld_* loader in, imem_* write out, core_rst, instr_i/res_i/expect_i, done/pass/timeout/cycle_cnt.
module riscv_boot_ctrl
  import riscv_boot_pkg::*;
#(
  parameter int              PROG_SIZE  = 7,
  parameter int              XLEN       = 32,
  parameter int              TIMEOUT    = 1000,
  parameter int              RST_HOLD   = 2,
  parameter logic [XLEN-1:0] HALT_INSTR = XLEN'(HALT_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            ld_valid,
  input  logic [XLEN-1:0] ld_data,
  input  logic            ld_last,
  output logic            ld_ready,
  output logic            imem_we,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] imem_wdata,
  output logic            core_rst,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] res_i,
  input  logic [XLEN-1:0] expect_i,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic [XLEN-1:0] cycle_cnt
);

  localparam int WORDS = word_count(PROG_SIZE);
  localparam int HW    = $clog2(RST_HOLD + 1) + 1;

  boot_state_t     r_state;
  boot_state_t     w_next;
  logic [XLEN-1:0] r_ptr;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_expect;
  logic [HW-1:0]   r_hold;
  logic            r_we;
  logic            r_done;
  logic            r_pass;
  logic            r_timeout;

  logic w_accept;
  logic w_last_slot;
  logic w_halt;
  logic w_start;
  logic w_run;
  logic w_expire;
  logic w_hold_done;
  logic w_ld_ready;
  logic w_core_rst;

  assign w_accept    = ld_valid && (r_state == LOAD);
  assign w_last_slot = (r_ptr == XLEN'(WORDS - 1));
  assign w_halt      = (instr_i == HALT_INSTR);
  assign w_start     = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_run       = (r_state == RUN);
  // HOLD spans the final write cycle plus RST_HOLD cycles of core reset.
  assign w_hold_done = (r_hold == HW'(RST_HOLD));

  boot_run_counter #(
    .XLEN   (XLEN),
    .TIMEOUT(TIMEOUT)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_start),
    .i_en    (w_run),
    .o_cnt   (cycle_cnt),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_ld_ready = 1'b0;
    w_core_rst = 1'b1;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = LOAD;
      end
      LOAD: begin
        w_ld_ready = 1'b1;
        if (ld_valid && (ld_last || w_last_slot)) w_next = HOLD;
      end
      HOLD: begin
        if (w_hold_done) w_next = RUN;
      end
      RUN: begin
        w_core_rst = 1'b0;
        if (w_halt || w_expire) w_next = DONE;
      end
      DONE: begin
        if (start) w_next = LOAD;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_expect  <= '0;
      r_hold    <= '0;
      r_we      <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_we   <= w_accept;
      r_hold <= (r_state == HOLD) ? r_hold + 1'b1 : '0;
      if (w_accept) begin
        r_addr  <= r_ptr << 2;
        r_wdata <= ld_data;
        r_ptr   <= r_ptr + 1'b1;
      end
      if (w_start) begin
        r_ptr     <= '0;
        r_expect  <= expect_i;
        r_done    <= 1'b0;
        r_pass    <= 1'b0;
        r_timeout <= 1'b0;
      end
      // Halt takes priority over a coincident timeout.
      if (w_run) begin
        if (w_halt) begin
          r_done <= 1'b1;
          r_pass <= (res_i == r_expect);
        end else if (w_expire) begin
          r_done    <= 1'b1;
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign ld_ready   = w_ld_ready;
  assign core_rst   = w_core_rst;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign done       = r_done;
  assign pass       = r_pass;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// tb_riscv_boot_ctrl: randomized self-checking bench for riscv_boot_ctrl.
// Drives a word-stream loader and a stand-in core fetch stream; predicts results from program contents.
module tb_riscv_boot_ctrl;

  localparam int          TO   = 20;
  localparam int          RH   = 2;
  localparam int          CAP  = 2;
  localparam logic [31:0] HALT = 32'h0000_006F;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0050_0513;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic [31:0] instr_i;
  logic [31:0] res_i;
  logic [31:0] expect_i;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [31:0] cycle_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;
  int last_we_cyc = 0;

  logic [31:0] prog [0:3];
  logic [31:0] wq_a[$];
  logic [31:0] wq_d[$];

  riscv_boot_ctrl #(
    .PROG_SIZE(7),
    .XLEN     (32),
    .TIMEOUT  (TO),
    .RST_HOLD (RH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_rst  (core_rst),
    .instr_i   (instr_i),
    .res_i     (res_i),
    .expect_i  (expect_i),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .cycle_cnt (cycle_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n++;

  // Instruction-memory image as seen by the bench.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wq_a.push_back(imem_addr);
      wq_d.push_back(imem_wdata);
      last_we_cyc = cyc_n;
    end
  end

  task automatic run_case(input string nm, input int len, input int last_at,
                          input bit gaps, input int poke_at, input int abort_at,
                          input logic [31:0] expv, input logic [31:0] resv);
    int          nwr;
    int          h;
    int          i;
    int          cyc;
    int          pc;
    logic [31:0] e_cnt;
    logic        e_pass;
    logic        e_to;
    nwr = 0;
    for (int k = 0; k < len; k++) begin
      nwr++;
      if (k == last_at || k == CAP - 1) break;
    end
    h = -1;
    for (int k = nwr - 1; k >= 0; k--) if (prog[k] == HALT) h = k;
    if (h >= 0 && h + 1 <= TO) begin
      e_cnt  = 32'(h + 1);
      e_pass = (resv == expv);
      e_to   = 1'b0;
    end else begin
      e_cnt  = 32'(TO);
      e_pass = 1'b0;
      e_to   = 1'b1;
    end
    wq_a.delete();
    wq_d.delete();
    res_i   = resv;
    instr_i = 32'h0;
    @(negedge clk);
    start    = 1'b1;
    expect_i = expv;
    @(negedge clk);
    start    = 1'b0;
    expect_i = ~expv;
    n_cmp++;
    if (done !== 1'b0 || cycle_cnt !== 32'h0 || ld_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s start: done=%b cnt=%0d rdy=%b want 0 0 1",
               nm, done, cycle_cnt, ld_ready);
    end
    i   = 0;
    cyc = 0;
    while (i < len && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (gaps && i < nwr && $urandom_range(0, 2) == 0) begin
        ld_valid = 1'b0;
      end else begin
        ld_valid = 1'b1;
        ld_data  = prog[i];
        ld_last  = (i == last_at);
        n_cmp++;
        if (ld_ready !== (i < nwr)) begin
          n_err++;
          $display("FAIL %s ld_ready word %0d: got %b want %b",
                   nm, i, ld_ready, (i < nwr));
        end
        i++;
      end
    end
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = $urandom;
    cyc = 0;
    while (core_rst === 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (core_rst !== 1'b0 || (cyc_n - last_we_cyc) != RH + 1) begin
      n_err++;
      $display("FAIL %s hold: core_rst=%b gap=%0d want 0 %0d",
               nm, core_rst, cyc_n - last_we_cyc, RH + 1);
    end
    n_cmp++;
    if (wq_a.size() != nwr) begin
      n_err++;
      $display("FAIL %s write count: got %0d want %0d", nm, wq_a.size(), nwr);
    end
    for (int k = 0; k < nwr && k < wq_a.size(); k++) begin
      n_cmp++;
      if (wq_a[k] !== 32'(4 * k) || wq_d[k] !== prog[k]) begin
        n_err++;
        $display("FAIL %s write %0d: got %h/%h want %h/%h",
                 nm, k, wq_a[k], wq_d[k], 32'(4 * k), prog[k]);
      end
    end
    pc = 0;
    while (done !== 1'b1 && pc < TO + 5) begin
      instr_i = (pc < nwr) ? prog[pc] : NOP;
      start   = (pc == poke_at);
      if (pc == abort_at) begin
        n_cmp++;
        if (cycle_cnt !== 32'(abort_at)) begin
          n_err++;
          $display("FAIL %s pre-abort cnt: got %0d want %0d", nm, cycle_cnt, abort_at);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (core_rst !== 1'b1 || ld_ready !== 1'b0 || imem_we !== 1'b0 ||
            imem_addr !== 32'h0 || imem_wdata !== 32'h0 || done !== 1'b0 ||
            pass !== 1'b0 || timeout !== 1'b0 || cycle_cnt !== 32'h0) begin
          n_err++;
          $display("FAIL %s abort: rst=%b rdy=%b we=%b a=%h d=%h dn=%b p=%b to=%b cnt=%0d",
                   nm, core_rst, ld_ready, imem_we, imem_addr, imem_wdata,
                   done, pass, timeout, cycle_cnt);
        end
        @(negedge clk);
        rst     = 1'b0;
        instr_i = 32'h0;
        @(negedge clk);
        n_cmp++;
        if (core_rst !== 1'b1 || ld_ready !== 1'b0 || imem_we !== 1'b0) begin
          n_err++;
          $display("FAIL %s post-abort: rst=%b rdy=%b we=%b want 1 0 0",
                   nm, core_rst, ld_ready, imem_we);
        end
        return;
      end
      @(negedge clk);
      pc++;
    end
    start   = 1'b0;
    instr_i = 32'h0;
    n_cmp++;
    if (done !== 1'b1 || pass !== e_pass || timeout !== e_to ||
        cycle_cnt !== e_cnt || core_rst !== 1'b1) begin
      n_err++;
      $display("FAIL %s result: dn=%b p=%b to=%b cnt=%0d rst=%b want 1 %b %b %0d 1",
               nm, done, pass, timeout, cycle_cnt, core_rst, e_pass, e_to, e_cnt);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || pass !== e_pass || timeout !== e_to ||
        cycle_cnt !== e_cnt || wq_a.size() != nwr) begin
      n_err++;
      $display("FAIL %s sticky: dn=%b p=%b to=%b cnt=%0d wr=%0d want 1 %b %b %0d %0d",
               nm, done, pass, timeout, cycle_cnt, wq_a.size(), e_pass, e_to, e_cnt, nwr);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b0;
    ld_valid = 1'b0;
    ld_data  = 32'h0;
    ld_last  = 1'b0;
    instr_i  = 32'h0;
    res_i    = 32'h0;
    expect_i = 32'h0;
    #21;
    n_cmp++;
    if (core_rst !== 1'b1 || ld_ready !== 1'b0 || done !== 1'b0 ||
        cycle_cnt !== 32'h0 || imem_we !== 1'b0 || pass !== 1'b0 ||
        timeout !== 1'b0 || imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset: rst=%b rdy=%b dn=%b cnt=%0d we=%b p=%b to=%b",
               core_rst, ld_ready, done, cycle_cnt, imem_we, pass, timeout);
    end
    rst = 1'b0;
  endtask

  task automatic test_pass();
    prog[0] = ADDI;
    prog[1] = HALT;
    run_case("pass", 2, 1, 1'b0, -1, -1, 32'd5, 32'd5);
  endtask

  task automatic test_fail();
    prog[0] = ADDI;
    prog[1] = HALT;
    run_case("fail", 2, 1, 1'b0, -1, -1, 32'd6, 32'd5);
  endtask

  task automatic test_timeout();
    prog[0] = ADDI;
    prog[1] = NOP;
    run_case("timeout", 2, 1, 1'b0, 5, -1, 32'd5, 32'd5);
  endtask

  task automatic test_capacity();
    prog[0] = ADDI;
    prog[1] = HALT;
    prog[2] = 32'hDEAD_BEEF;
    run_case("capacity", 3, -1, 1'b0, -1, -1, 32'd5, 32'd5);
  endtask

  task automatic test_gap_rst();
    prog[0] = ADDI;
    prog[1] = NOP;
    run_case("gap_rst", 2, 1, 1'b1, -1, 6, 32'd5, 32'd5);
  endtask

  task automatic test_back_to_back();
    int          len;
    int          last_at;
    logic [31:0] ev;
    logic [31:0] rv;
    for (int n = 0; n < 12; n++) begin
      len     = int'($urandom_range(1, 3));
      last_at = int'($urandom_range(0, len)) - 1;
      if (len < CAP && last_at < 0) last_at = len - 1;
      for (int k = 0; k < 4; k++)
        prog[k] = ($urandom_range(0, 2) == 0) ? HALT : (($urandom & ~32'h7F) | NOP);
      ev = $urandom;
      rv = ($urandom_range(0, 1) == 0) ? ev : (ev ^ (32'h1 << $urandom_range(0, 31)));
      run_case("random", len, last_at, 1'b1, -1, -1, ev, rv);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_capacity();
    test_gap_rst();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
